// File: rtl/chan_scatter_gather.sv
// Bidirectional channel gather/scatter between a multi-lane NoC port and a wide tile vector.
// Ingress packs flits into one frame; egress splits a frame back into flits.

module chan_sg_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk_tl,
    input  logic         rst_tl,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          push_ok, pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    // Head is gated so a freshly reset FIFO presents zero instead of stale storage.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_tl) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_tl) begin
        if (rst_tl) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module chan_scatter_gather #(
    parameter  int QW    = 8,
    parameter  int XW    = 128,
    parameter  int LANES = 1,
    parameter  int DEPTH = 8,
    localparam int FW    = LANES*QW,
    localparam int CW    = $clog2(XW+1)
) (
    input  logic                   clk_tl,
    input  logic                   rst_tl,
    input  logic [CW-1:0]          cfg_chans,
    input  logic [FW-1:0]          nw_data_i,
    input  logic                   nw_valid_i,
    output logic                   nw_ready_o,
    output logic [XW-1:0][QW-1:0]  tl_data_o,
    output logic                   tl_valid_o,
    input  logic                   tl_ready_i,
    input  logic [XW-1:0][QW-1:0]  tl_data_i,
    input  logic                   tl_valid_i,
    output logic                   tl_ready_o,
    output logic [FW-1:0]          nw_data_o,
    output logic                   nw_valid_o,
    input  logic                   nw_ready_i,
    output logic                   ig_busy,
    output logic                   eg_busy
);
    localparam int NF = XW/LANES;

    typedef enum logic {IG_GATHER, IG_HOLD} ig_state_t;
    typedef enum logic {EG_IDLE, EG_SPLIT} eg_state_t;

    function automatic logic [CW-1:0] eff_chans(input logic [CW-1:0] c);
        return (c == '0 || c > CW'(XW)) ? CW'(XW) : c;
    endfunction

    function automatic logic [CW-1:0] last_flit(input logic [CW-1:0] n);
        int t;
        t = (int'(n) + LANES - 1) / LANES - 1;
        return CW'(t);
    endfunction

    // ---------------- ingress ----------------
    ig_state_t             ig_state_q, ig_state_d;
    logic [CW-1:0]         fcnt_q, n_ig_q, n_ig_cur;
    logic [NF-1:0][FW-1:0] gat_q;
    logic [XW*QW-1:0]      gat_flat;
    logic [FW-1:0]         ib_head;
    logic                  ib_empty, ib_full, ib_pop, ig_last;

    chan_sg_fifo #(.W(FW), .DEPTH(DEPTH)) u_ibuf (
        .clk_tl (clk_tl), .rst_tl (rst_tl),
        .push_i (nw_valid_i), .data_i (nw_data_i),
        .pop_i  (ib_pop), .data_o (ib_head),
        .full_o (ib_full), .empty_o (ib_empty)
    );
    assign nw_ready_o = ~ib_full;

    // The channel count is taken live on a frame's first pop, then held.
    assign n_ig_cur = (fcnt_q == '0) ? eff_chans(cfg_chans) : n_ig_q;
    assign ig_last  = (fcnt_q == last_flit(n_ig_cur));

    always_ff @(posedge clk_tl) begin
        if (rst_tl) ig_state_q <= IG_GATHER;
        else        ig_state_q <= ig_state_d;
    end

    always_comb begin
        ig_state_d = ig_state_q;
        case (ig_state_q)
            IG_GATHER: if (ib_pop && ig_last) ig_state_d = IG_HOLD;
            IG_HOLD:   if (tl_ready_i)        ig_state_d = IG_GATHER;
            default:   ig_state_d = IG_GATHER;
        endcase
    end

    always_comb begin
        ib_pop     = 1'b0;
        tl_valid_o = 1'b0;
        case (ig_state_q)
            IG_GATHER: ib_pop     = ~ib_empty;
            IG_HOLD:   tl_valid_o = 1'b1;
            default:   ib_pop     = 1'b0;
        endcase
    end
    assign ig_busy = (ig_state_q == IG_HOLD) | (fcnt_q != '0);

    always_ff @(posedge clk_tl) begin
        if (rst_tl) begin
            fcnt_q <= '0;
            n_ig_q <= CW'(XW);
            gat_q  <= '0;
        end else if (ib_pop) begin
            n_ig_q <= n_ig_cur;
            fcnt_q <= ig_last ? '0 : fcnt_q + 1'b1;
            for (int f = 0; f < NF; f++) begin
                if (fcnt_q == CW'(f)) gat_q[f] <= ib_head;
            end
        end
    end

    assign gat_flat = gat_q;
    for (genvar gi = 0; gi < XW; gi++) begin : g_mask
        assign tl_data_o[gi] = (CW'(gi) < n_ig_q) ? gat_flat[gi*QW +: QW] : '0;
    end

    // ---------------- egress ----------------
    eg_state_t             eg_state_q, eg_state_d;
    logic [CW-1:0]         ocnt_q, n_eg_q;
    logic [NF-1:0][FW-1:0] sc_q;
    logic [FW-1:0]         flit_raw, ob_din;
    logic                  ob_full, ob_empty, ob_push, eg_last;

    assign eg_last = (ocnt_q == last_flit(n_eg_q));

    always_ff @(posedge clk_tl) begin
        if (rst_tl) eg_state_q <= EG_IDLE;
        else        eg_state_q <= eg_state_d;
    end

    always_comb begin
        eg_state_d = eg_state_q;
        case (eg_state_q)
            EG_IDLE:  if (tl_valid_i)          eg_state_d = EG_SPLIT;
            EG_SPLIT: if (ob_push && eg_last)  eg_state_d = EG_IDLE;
            default:  eg_state_d = EG_IDLE;
        endcase
    end

    always_comb begin
        tl_ready_o = 1'b0;
        ob_push    = 1'b0;
        eg_busy    = 1'b0;
        case (eg_state_q)
            EG_IDLE:  tl_ready_o = 1'b1;
            EG_SPLIT: begin
                ob_push = ~ob_full;
                eg_busy = 1'b1;
            end
            default:  tl_ready_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk_tl) begin
        if (rst_tl) begin
            ocnt_q <= '0;
            n_eg_q <= CW'(XW);
            sc_q   <= '0;
        end else begin
            if (tl_valid_i && tl_ready_o) begin
                sc_q   <= tl_data_i;
                n_eg_q <= eff_chans(cfg_chans);
            end
            if (ob_push) ocnt_q <= eg_last ? '0 : ocnt_q + 1'b1;
        end
    end

    // Lanes past the latched channel count are zeroed on the way out.
    always_comb begin
        flit_raw = '0;
        for (int f = 0; f < NF; f++) begin
            if (ocnt_q == CW'(f)) flit_raw = sc_q[f];
        end
        ob_din = '0;
        for (int k = 0; k < LANES; k++) begin
            if (int'(ocnt_q)*LANES + k < int'(n_eg_q)) ob_din[k*QW +: QW] = flit_raw[k*QW +: QW];
        end
    end

    chan_sg_fifo #(.W(FW), .DEPTH(DEPTH)) u_obuf (
        .clk_tl (clk_tl), .rst_tl (rst_tl),
        .push_i (ob_push), .data_i (ob_din),
        .pop_i  (nw_ready_i), .data_o (nw_data_o),
        .full_o (ob_full), .empty_o (ob_empty)
    );
    assign nw_valid_o = ~ob_empty;
endmodule

// File: tb/tb_chan_scatter_gather.sv
// Scoreboard bench: instance A (4 lanes) and instance B (1 lane), both 16 channels of 8 bits.
module tb_chan_scatter_gather;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_a, rst_b;
    logic [4:0]        cfg_a, cfg_b;
    logic [31:0]       nw_data_i_a, nw_data_o_a;
    logic [7:0]        nw_data_i_b, nw_data_o_b;
    logic [15:0][7:0]  tl_data_o_a, tl_data_i_a, tl_data_o_b, tl_data_i_b;
    logic nw_valid_i_a, nw_ready_o_a, tl_valid_o_a, tl_ready_i_a, tl_valid_i_a, tl_ready_o_a;
    logic nw_valid_o_a, nw_ready_i_a, ig_busy_a, eg_busy_a;
    logic nw_valid_i_b, nw_ready_o_b, tl_valid_o_b, tl_ready_i_b, tl_valid_i_b, tl_ready_o_b;
    logic nw_valid_o_b, nw_ready_i_b, ig_busy_b, eg_busy_b;

    chan_scatter_gather #(.QW(8), .XW(16), .LANES(4), .DEPTH(8)) u_a (
        .clk_tl(clk), .rst_tl(rst_a), .cfg_chans(cfg_a),
        .nw_data_i(nw_data_i_a), .nw_valid_i(nw_valid_i_a), .nw_ready_o(nw_ready_o_a),
        .tl_data_o(tl_data_o_a), .tl_valid_o(tl_valid_o_a), .tl_ready_i(tl_ready_i_a),
        .tl_data_i(tl_data_i_a), .tl_valid_i(tl_valid_i_a), .tl_ready_o(tl_ready_o_a),
        .nw_data_o(nw_data_o_a), .nw_valid_o(nw_valid_o_a), .nw_ready_i(nw_ready_i_a),
        .ig_busy(ig_busy_a), .eg_busy(eg_busy_a));

    chan_scatter_gather #(.QW(8), .XW(16), .LANES(1), .DEPTH(8)) u_b (
        .clk_tl(clk), .rst_tl(rst_b), .cfg_chans(cfg_b),
        .nw_data_i(nw_data_i_b), .nw_valid_i(nw_valid_i_b), .nw_ready_o(nw_ready_o_b),
        .tl_data_o(tl_data_o_b), .tl_valid_o(tl_valid_o_b), .tl_ready_i(tl_ready_i_b),
        .tl_data_i(tl_data_i_b), .tl_valid_i(tl_valid_i_b), .tl_ready_o(tl_ready_o_b),
        .nw_data_o(nw_data_o_b), .nw_valid_o(nw_valid_o_b), .nw_ready_i(nw_ready_i_b),
        .ig_busy(ig_busy_b), .eg_busy(eg_busy_b));

    int n_checks = 0;
    int n_pass   = 0;
    logic [127:0] q_tl_a[$];
    logic [127:0] q_tl_b[$];
    logic [31:0]  q_nw_a[$];
    logic [7:0]   q_nw_b[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] ramp(input int base, input int n);
        logic [127:0] v = '0;
        for (int i = 0; i < n; i++) v[i*8 +: 8] = 8'(base + i);
        return v;
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst_a && tl_valid_o_a && tl_ready_i_a) begin
            if (q_tl_a.size() == 0) begin
                n_checks++;
                $display("FAIL tl_a_unexpected: actual frame %0h required none", tl_data_o_a);
            end else check("tl_a_frame", tl_data_o_a, q_tl_a.pop_front());
            $display("tl_a frame %h", tl_data_o_a);
        end
    end

    always @(negedge clk) begin
        if (!rst_b && tl_valid_o_b && tl_ready_i_b) begin
            if (q_tl_b.size() == 0) begin
                n_checks++;
                $display("FAIL tl_b_unexpected: actual frame %0h required none", tl_data_o_b);
            end else check("tl_b_frame", tl_data_o_b, q_tl_b.pop_front());
            $display("tl_b frame %h", tl_data_o_b);
        end
    end

    always @(negedge clk) begin
        if (!rst_a && nw_valid_o_a && nw_ready_i_a) begin
            if (q_nw_a.size() == 0) begin
                n_checks++;
                $display("FAIL nw_a_unexpected: actual flit %0h required none", nw_data_o_a);
            end else check("nw_a_flit", 128'(nw_data_o_a), 128'(q_nw_a.pop_front()));
            $display("nw_a flit %h", nw_data_o_a);
        end
    end

    always @(negedge clk) begin
        if (!rst_b && nw_valid_o_b && nw_ready_i_b) begin
            if (q_nw_b.size() == 0) begin
                n_checks++;
                $display("FAIL nw_b_unexpected: actual flit %0h required none", nw_data_o_b);
            end else check("nw_b_flit", 128'(nw_data_o_b), 128'(q_nw_b.pop_front()));
            $display("nw_b flit %h", nw_data_o_b);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_a(input logic [31:0] d);
        int w = 0;
        nw_data_i_a  = d;
        nw_valid_i_a = 1'b1;
        while (!nw_ready_o_a && w < 100) begin
            tick();
            w++;
        end
        if (w == 100) begin
            n_checks++;
            $display("FAIL send_a_timeout: actual ready 0 required 1");
        end
        tick();
        nw_valid_i_a = 1'b0;
    endtask

    task automatic drain(input string name);
        int c = 0;
        while ((q_tl_a.size() + q_tl_b.size() + q_nw_a.size() + q_nw_b.size()) != 0 && c < 400) begin
            tick();
            c++;
        end
        check(name, 128'(c < 400), 128'(1));
        tick();
    endtask

    initial begin
        int sent, cyc, low_seen, acc_at_drop, seen;
        logic accept;
        rst_a = 1'b1; rst_b = 1'b1;
        cfg_a = '0; cfg_b = '0;
        nw_data_i_a = '0; nw_valid_i_a = 1'b0; tl_ready_i_a = 1'b1;
        tl_data_i_a = '0; tl_valid_i_a = 1'b0; nw_ready_i_a = 1'b1;
        nw_data_i_b = '0; nw_valid_i_b = 1'b0; tl_ready_i_b = 1'b1;
        tl_data_i_b = '0; tl_valid_i_b = 1'b0; nw_ready_i_b = 1'b1;
        repeat (3) tick();
        rst_a = 1'b0; rst_b = 1'b0;

        // Reset state
        check("rst_nw_ready",  128'(nw_ready_o_a), 128'(1));
        check("rst_tl_ready",  128'(tl_ready_o_a), 128'(1));
        check("rst_tl_valid",  128'(tl_valid_o_a), 128'(0));
        check("rst_nw_valid",  128'(nw_valid_o_a), 128'(0));
        check("rst_tl_data",   tl_data_o_a, 128'(0));
        check("rst_nw_data",   128'(nw_data_o_a), 128'(0));
        check("rst_busy",      128'({ig_busy_a, eg_busy_a, ig_busy_b, eg_busy_b}), 128'(0));
        check("rst_b_ready",   128'({nw_ready_o_b, tl_ready_o_b}), 128'(2'b11));
        tick();

        // Partial last flit, N=10
        cfg_a = 5'd10;
        q_tl_a.push_back(ramp(0, 10));
        send_a(32'h03020100);
        send_a(32'h07060504);
        send_a(32'h0B0A0908);
        check("ig_valid_before_last_pop", 128'(tl_valid_o_a), 128'(0));
        check("ig_busy_mid_frame", 128'(ig_busy_a), 128'(1));
        tick();
        check("ig_valid_after_last_pop", 128'(tl_valid_o_a), 128'(1));
        drain("drain_partial");

        // Egress scatter, N=6
        cfg_a = 5'd6;
        for (int i = 0; i < 16; i++) tl_data_i_a[i] = 8'(8'h10 + i);
        q_nw_a.push_back(32'h13121110);
        q_nw_a.push_back(32'h00001514);
        tl_valid_i_a = 1'b1;
        check("eg_ready_idle", 128'(tl_ready_o_a), 128'(1));
        tick();
        tl_valid_i_a = 1'b0;
        check("eg_ready_low_1", 128'(tl_ready_o_a), 128'(0));
        check("eg_nw_valid_t1", 128'(nw_valid_o_a), 128'(0));
        check("eg_busy_split", 128'(eg_busy_a), 128'(1));
        tick();
        check("eg_ready_low_2", 128'(tl_ready_o_a), 128'(0));
        check("eg_nw_valid_t2", 128'(nw_valid_o_a), 128'(1));
        tick();
        check("eg_ready_back", 128'(tl_ready_o_a), 128'(1));
        drain("drain_scatter");

        // Ingress backpressure on B, N=4, 20 flits, frame output held at first
        cfg_b = 5'd4;
        tl_ready_i_b = 1'b0;
        for (int j = 0; j < 5; j++) q_tl_b.push_back(ramp(4*j, 4));
        sent = 0; cyc = 0; low_seen = 0; acc_at_drop = -1;
        while (sent < 20 && cyc < 300) begin
            nw_data_i_b  = 8'(sent);
            nw_valid_i_b = 1'b1;
            accept = nw_ready_o_b;
            if (!accept) begin
                if (acc_at_drop < 0) acc_at_drop = sent;
                low_seen++;
            end
            if (low_seen == 4) tl_ready_i_b = 1'b1;
            tick();
            if (accept) sent++;
            cyc++;
        end
        nw_valid_i_b = 1'b0;
        check("bp_accepted_before_full", 128'(acc_at_drop), 128'(12));
        check("bp_all_sent", 128'(sent), 128'(20));
        drain("drain_ig_bp");
        check("bp_ig_idle", 128'(ig_busy_b), 128'(0));

        // Egress backpressure on B, N=16
        cfg_b = 5'd16;
        nw_ready_i_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tl_data_i_b[i] = 8'(8'hA0 + i);
            q_nw_b.push_back(8'(8'hA0 + i));
        end
        tl_valid_i_b = 1'b1;
        check("ebp_ready_idle", 128'(tl_ready_o_b), 128'(1));
        tick();
        tl_valid_i_b = 1'b0;
        repeat (12) tick();
        check("ebp_stalled_busy", 128'({eg_busy_b, tl_ready_o_b, nw_valid_o_b}), 128'(3'b101));
        check("ebp_ocnt_held", 128'(u_b.ocnt_q), 128'(8));
        nw_ready_i_b = 1'b1;
        drain("drain_eg_bp");
        check("ebp_done", 128'({eg_busy_b, tl_ready_o_b}), 128'(2'b01));

        // Mid-frame cfg change on A: frame keeps N=8
        cfg_a = 5'd8;
        q_tl_a.push_back(ramp(8'h20, 8));
        send_a(32'h23222120);
        tick();
        cfg_a = 5'd4;
        send_a(32'h27262524);
        drain("drain_cfg_change");

        // Reset during a partial frame
        cfg_a = 5'd8;
        nw_data_i_a = 32'h41414141; nw_valid_i_a = 1'b1;
        tick();
        nw_data_i_a = 32'h42424242;
        tick();
        rst_a = 1'b1;
        nw_data_i_a = 32'h43434343;
        tick();
        tick();
        rst_a = 1'b0;
        nw_valid_i_a = 1'b0;
        check("mrst_outputs", 128'({nw_ready_o_a, tl_valid_o_a, ig_busy_a, nw_valid_o_a}), 128'(4'b1000));
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (tl_valid_o_a || ig_busy_a) seen++;
            tick();
        end
        check("mrst_fifo_empty", 128'(seen), 128'(0));
        q_tl_a.push_back(ramp(8'h30, 8));
        send_a(32'h33323130);
        send_a(32'h37363534);
        drain("drain_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/chan_scatter_gather.md
# chan_scatter_gather

Single-clock, parametrised successor of the tile merge I/O stage. It sits between the NoC port and the tile compute array. The ingress path gathers multi-lane network flits into one `XW`-channel parallel vector. The egress path scatters a parallel tile vector back into flits. The channel count is runtime-programmable, with per-frame latching, lane packing and proper valid/ready backpressure on all four interfaces.

## Interface
- `QW`, 8: bits per channel.
- `XW`, 128: maximum channels per frame.
- `LANES`, 1: channels carried per flit; `XW % LANES == 0`.
- `DEPTH`, 8: entries in each sync FIFO, power of 2, ≥2.
- `FW` (derived) = `LANES*QW`: flit width. `CW` (derived) = `$clog2(XW+1)`.
- `clk_tl` in 1: single clock for the whole block.
- `rst_tl` in 1: synchronous, active-high reset.
- `cfg_chans` in CW: valid channel count N, latched per frame. 0 or >XW is treated as XW.
- `nw_data_i` in FW, `nw_valid_i` in 1, `nw_ready_o` out 1: ingress flits. Lane k carries channel `base+k`.
- `tl_data_o` out QW×[XW], `tl_valid_o` out 1, `tl_ready_i` in 1: gathered frame.
- `tl_data_i` in QW×[XW], `tl_valid_i` in 1, `tl_ready_o` out 1: frame to scatter.
- `nw_data_o` out FW, `nw_valid_o` out 1, `nw_ready_i` in 1: egress flits.
- `ig_busy` out 1, `eg_busy` out 1: a frame is in progress on that path.

## Operation
- The flit count per frame is F = ceil(N/LANES).
- Ingress FIFO (ibuf):
  - Push on `nw_valid_i & nw_ready_o`.
  - `nw_ready_o = ~full`. When full, no push occurs even if a pop happens in the same cycle.
  - Registered output, no fall-through.
- Ingress FSM, GATHER state:
  - On the first pop of a frame, latch N_ig from `cfg_chans`.
  - Each pop writes the flit into gather register channels `[fcnt*LANES +: LANES]`, then `fcnt++`.
  - Pops occur whenever ibuf is non-empty.
  - On the pop with `fcnt == F-1`, go to HOLD and set `fcnt = 0`.
- Ingress FSM, HOLD state:
  - `tl_valid_o = 1` and no pops occur.
  - On `tl_ready_i`, return to GATHER. A pop may occur in the following cycle, not in the same cycle.
- `tl_data_o[i]` is the gather register for `i < N_ig`, otherwise 0.
  - This includes lanes ≥ N_ig inside the last flit.
  - The data is stable throughout HOLD.
- Egress FSM, IDLE state:
  - `tl_ready_o = 1`.
  - On `tl_valid_i`, capture all XW channels into the scatter register, latch N_eg from `cfg_chans`, and go to SPLIT.
- Egress FSM, SPLIT state:
  - `tl_ready_o = 0`.
  - Each cycle obuf is not full, push flit `ocnt`: channels `[ocnt*LANES +: LANES]`, with channels ≥ N_eg zeroed. Then `ocnt++`.
  - After pushing flit F-1, return to IDLE and set `ocnt = 0`.
- Egress FIFO (obuf):
  - `nw_valid_o = ~empty`; `nw_data_o` = head.
  - Pop on `nw_valid_o & nw_ready_i`.
- `ig_busy` = `(state == HOLD) | (fcnt != 0)`; `eg_busy` = `(state == SPLIT)`.
- The two paths are fully independent. Changing `cfg_chans` mid-frame has no effect until the next frame's latch point.

## Timing
- Reset (`rst_tl` high at a clock edge):
  - FIFOs empty; FSMs return to GATHER and IDLE; counters 0.
  - Gather and scatter registers 0.
  - Outputs: `nw_ready_o = 1`, `tl_valid_o = 0`, `tl_ready_o = 1`, `nw_valid_o = 0`, `tl_data_o` all 0, `nw_data_o = 0`, `ig_busy = eg_busy = 0`.
  - All inputs are ignored while `rst_tl` is high.
  - Reset mid-frame discards partial frames and FIFO contents without emitting anything.
- Ingress latency:
  - A flit accepted at cycle t is popped at t+1 at the earliest.
  - The last flit popped at cycle p gives `tl_valid_o = 1` at p+1.
  - For F=1, accept at t gives `tl_valid_o` at t+2.
  - Sustained throughput is 1 flit/cycle except the single HOLD-release bubble.
- Egress latency:
  - Frame accepted at t gives flit 0 pushed at t+1 and `nw_valid_o = 1` at t+2.
  - Flits then follow at 1/cycle with no backpressure.
  - The next frame is accepted at the earliest one cycle after the last push.
- Backpressure:
  - obuf full stalls SPLIT with `ocnt` held.
  - Held HOLD lets ibuf fill; `nw_ready_o` drops on the cycle the count reaches DEPTH.
- Simultaneous push and pop on a non-full FIFO is legal and leaves the count unchanged.
- The FIFO pointers wrap modulo DEPTH. A separate count of log2(DEPTH)+1 bits distinguishes full from empty.

## Test plan
- Reset state: QW=8, LANES=4, XW=16, no traffic, then deassert reset.
  - Required: `nw_ready_o = 1`, `tl_ready_o = 1`, `tl_valid_o = 0`, `nw_valid_o = 0`, `tl_data_o` all 0.
- Partial last flit on ingress: N=10; send flits 0x03020100, 0x07060504, 0x0B0A0908.
  - Required: `tl_valid_o` 1 cycle after the third pop; `tl_data_o[0..9] = 0..9`; `tl_data_o[10..15] = 0` (0x0A, 0x0B masked).
- Egress scatter: N=6; `tl_data_i[i] = 0x10+i`.
  - Required: `nw_data_o` = 0x13121110, then 0x00001514.
  - `tl_ready_o` low for 2 cycles; `nw_valid_o` first at t+2.
- Ingress backpressure: hold `tl_ready_i = 0` with N=4, LANES=1, and stream 20 flits.
  - Required: `nw_ready_o` falls after DEPTH=8 buffered flits beyond the held frame.
  - Frames are released in order with no loss once ready returns.
- Egress backpressure: `nw_ready_i = 0` for 12 cycles with N=16, LANES=1.
  - Required: exactly 8 flits queued, SPLIT stalls at `ocnt = 8`, resumes on ready, and all 16 flits come out in order.
- Mid-frame config and reset:
  - Change `cfg_chans` 8→4 after the 1st of 2 flits. Required: the frame completes with N=8.
  - Assert `rst_tl` during the next partial frame. Required: no `tl_valid_o`, the FIFO is empty, and the next frame gathers cleanly.
